rr_priority_arbiter: RTL and testbench
======================================

Name: rr_priority_arbiter

Overview:
Parametrised successor to the 8-to-3 priority encoder. It takes N request lines and selects one winner per transaction. Two modes are supported: fixed priority (highest index wins) and round-robin (rotating fairness pointer). The winner's index and one-hot grant are registered behind a valid/ready output handshake. It sits between request sources (e.g. interrupt lines or channel FIFOs' non-empty flags) and a single shared consumer.

Parameters:
N, 8, number of request lines; legal range 2..32.
IDX_W, $clog2(N), width of the encoded index output; derived, never overridden.

Ports:
clk  input  1  single clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset; deassertion is synchronous to clk, handled upstream.
req_in  input  N  request vector; bit i is request i; level-sensitive, sampled only on a capture cycle.
rr_mode  input  1  0 = fixed priority (bit N-1 highest, bit 0 lowest); 1 = round-robin.
out_valid  output  1  a registered grant is present.
out_ready  input  1  consumer accepts the grant when out_valid && out_ready.
out_idx  output  IDX_W  binary index of the granted request.
out_onehot  output  N  one-hot grant; equals 1<<out_idx when out_valid, else all zero.
any_req  output  1  combinational OR of req_in, unregistered.

Behaviour:
- Reset (rst_n=0, async): out_valid=0, out_idx=0, out_onehot=0, rr pointer ptr=N-1. No output changes until the first clk edge after release.
- Capture cycle: a rising edge where (!out_valid || out_ready) holds.
  - If |req_in=1: load the grant and set out_valid=1.
  - Otherwise: set out_valid=0 and drive out_onehot=0; out_idx holds its last value.
- Latency is 1 cycle from sampled request to out_valid.
- Throughput is one grant per cycle when out_ready is held at 1.
- Hold rule: while out_valid && !out_ready, out_idx and out_onehot stay frozen regardless of req_in changes, including deassertion of the granted request. No retraction.
- Fixed mode: the winner is the highest set index of req_in. ptr is ignored but still updated.
- Round-robin mode:
  - Search starts at index ptr and descends: ptr, ptr-1, ..., 0, N-1, ..., ptr+1, wrapping modulo N.
  - The first set bit wins.
- ptr update: on every capture that loads a grant g, ptr <= (g==0) ? N-1 : g-1, in both modes. ptr is unchanged on a capture with no requests and while stalled.
- Mode switch: rr_mode is sampled on capture cycles only. A change while stalled takes effect at the next capture.
- Single request: the same index is granted in both modes.
- All requests set in round-robin mode with out_ready=1: grants cycle N-1, N-2, ..., 0, N-1, ...
- Implementation: round-robin uses a double-width masked priority scan or an equivalent rotate-scan-unrotate. Fixed mode uses a descending priority scan. No latches; no combinational path from out_ready to out_idx.

Test Plan:
- Reset and idle: assert rst_n=0 mid-transfer while out_valid=1 -> out_valid, out_idx and out_onehot go to 0 immediately, before any clk edge. After release with req_in=0 -> out_valid stays 0 and any_req=0.
- Fixed priority, N=8: rr_mode=0, out_ready=1, req_in=8'b0101_0010 held for 3 cycles -> out_idx=6 and out_onehot=8'b0100_0000 on every cycle. req_in=8'b0000_0001 -> out_idx=0.
- Round-robin rotation, N=8: rr_mode=1, req_in=8'hFF, out_ready=1 for 10 cycles -> out_idx sequence 7,6,5,4,3,2,1,0,7,6.
- Round-robin skip: rr_mode=1, after grant 5 (ptr=4), req_in=8'b1010_0000 -> next grant 7, then ptr=6 -> next grant 5.
- Backpressure: out_valid=1, out_idx=3, out_ready=0 for 4 cycles while req_in changes to 8'h80 -> out_idx stays 3 throughout. On out_ready=1 -> the transfer completes and the next cycle shows out_idx=7.
- Parameter sweep: repeat the rotation test with N=2, N=5 and N=32 -> grants descend with wrap, IDX_W is 1, 3 and 5, and a scoreboard confirms no request starves beyond N grants.

Source files
------------

// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: N-input fixed-priority / round-robin arbiter, registered valid/ready grant.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module rr_priority_arbiter #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_in,
  input  logic             rr_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             any_req
);

  localparam logic [IDX_W-1:0] C_PTR_INIT = IDX_W'(N - 1);
  localparam logic [N-1:0]     C_ONE      = {{(N-1){1'b0}}, 1'b1};

  // Highest set bit of v; zero when v is empty (callers gate on any_req).
  function automatic logic [IDX_W-1:0] highest(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  logic [IDX_W-1:0] r_ptr;
  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_masked;
  logic [IDX_W-1:0] w_fixed_idx;
  logic [IDX_W-1:0] w_rr_idx;
  logic [IDX_W-1:0] w_grant;
  logic             w_capture;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (IDX_W'(i) <= r_ptr);
    end
  end

  // Descending search from ptr: highest request at or below ptr, else wrap to the overall highest.
  assign w_masked    = req_in & w_mask;
  assign w_fixed_idx = highest(req_in);
  assign w_rr_idx    = (|w_masked) ? highest(w_masked) : w_fixed_idx;
  assign w_grant     = rr_mode ? w_rr_idx : w_fixed_idx;
  assign any_req     = |req_in;
  assign w_capture   = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      r_ptr      <= C_PTR_INIT;
    end else if (w_capture) begin
      if (any_req) begin
        out_valid  <= 1'b1;
        out_idx    <= w_grant;
        out_onehot <= C_ONE << w_grant;
        r_ptr      <= (w_grant == '0) ? C_PTR_INIT : (w_grant - 1'b1);
      end else begin
        out_valid  <= 1'b0;
        out_onehot <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_priority_arbiter.sv
// tb_rr_priority_arbiter: scoreboard bench for rr_priority_arbiter (N=8 directed, N=2/5/32 rotation).
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_rr_priority_arbiter;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] oh;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  logic [7:0] req8;
  logic       mode8, rdy8;
  logic       v8, any8;
  logic [2:0] idx8;
  logic [7:0] oh8;

  logic        sw_mode, sw_rdy;
  logic [1:0]  req2;
  logic [4:0]  req5;
  logic [31:0] req32;
  logic        v2, v5, v32, any2, any5, any32;
  logic [0:0]  idx2;
  logic [2:0]  idx5;
  logic [4:0]  idx32;
  logic [1:0]  oh2;
  logic [4:0]  oh5;
  logic [31:0] oh32;

  exp_t q8[$], q2[$], q5[$], q32[$];
  int   errors = 0;
  int   checks = 0;
  int   wcnt[3][32];

  always #5 clk = ~clk;

  rr_priority_arbiter #(.N(8)) u_d8 (
    .clk(clk), .rst_n(rst_n), .req_in(req8), .rr_mode(mode8), .out_valid(v8),
    .out_ready(rdy8), .out_idx(idx8), .out_onehot(oh8), .any_req(any8));
  rr_priority_arbiter #(.N(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .req_in(req2), .rr_mode(sw_mode), .out_valid(v2),
    .out_ready(sw_rdy), .out_idx(idx2), .out_onehot(oh2), .any_req(any2));
  rr_priority_arbiter #(.N(5)) u_d5 (
    .clk(clk), .rst_n(rst_n), .req_in(req5), .rr_mode(sw_mode), .out_valid(v5),
    .out_ready(sw_rdy), .out_idx(idx5), .out_onehot(oh5), .any_req(any5));
  rr_priority_arbiter #(.N(32)) u_d32 (
    .clk(clk), .rst_n(rst_n), .req_in(req32), .rr_mode(sw_mode), .out_valid(v32),
    .out_ready(sw_rdy), .out_idx(idx32), .out_onehot(oh32), .any_req(any32));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // d: 0=N2, 1=N5, 2=N32, 3=N8
  task automatic push(input int d, input int idx);
    exp_t e;
    e.idx = idx[4:0];
    e.oh  = 32'd1 << idx;
    case (d)
      0:       q2.push_back(e);
      1:       q5.push_back(e);
      2:       q32.push_back(e);
      default: q8.push_back(e);
    endcase
  endtask

  task automatic starve(input int d, input int n, input int g, input string name);
    int mx = 0;
    for (int i = 0; i < n; i++) begin
      if (i == g) wcnt[d][i] = 0;
      else        wcnt[d][i]++;
      if (wcnt[d][i] > mx) mx = wcnt[d][i];
    end
    chk(name, 64'(mx >= n), 64'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got grant with empty scoreboard, expected none at %0t", name, $time);
  endtask

  // Monitors: a grant is consumed when valid && ready at the coming edge.
  exp_t e8, e2, e5, e32;
  always @(negedge clk) begin
    if (rst_n && v8 && rdy8) begin
      if (q8.size() == 0) unexpected("d8_grant");
      else begin
        e8 = q8.pop_front();
        chk("d8_idx", 64'(idx8), 64'(e8.idx));
        chk("d8_onehot", 64'(oh8), 64'(e8.oh));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v2 && sw_rdy) begin
      if (q2.size() == 0) unexpected("n2_grant");
      else begin
        e2 = q2.pop_front();
        chk("n2_idx", 64'(idx2), 64'(e2.idx));
        chk("n2_onehot", 64'(oh2), 64'(e2.oh));
        starve(0, 2, int'(idx2), "n2_starve");
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v5 && sw_rdy) begin
      if (q5.size() == 0) unexpected("n5_grant");
      else begin
        e5 = q5.pop_front();
        chk("n5_idx", 64'(idx5), 64'(e5.idx));
        chk("n5_onehot", 64'(oh5), 64'(e5.oh));
        starve(1, 5, int'(idx5), "n5_starve");
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && v32 && sw_rdy) begin
      if (q32.size() == 0) unexpected("n32_grant");
      else begin
        e32 = q32.pop_front();
        chk("n32_idx", 64'(idx32), 64'(e32.idx));
        chk("n32_onehot", 64'(oh32), 64'(e32.oh));
        starve(2, 32, int'(idx32), "n32_starve");
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; req8 = '0; mode8 = 1'b0; rdy8 = 1'b1;
    sw_mode = 1'b1; sw_rdy = 1'b1; req2 = '0; req5 = '0; req32 = '0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 32; i++) wcnt[d][i] = 0;
    #2;
    chk("reset_valid", 64'(v8), 64'd0);
    chk("reset_idx", 64'(idx8), 64'd0);
    chk("reset_onehot", 64'(oh8), 64'd0);
    step();
    step();
    rst_n = 1'b1;

    // Idle after release
    step();
    step();
    chk("idle_valid", 64'(v8), 64'd0);
    chk("idle_any_req", 64'(any8), 64'd0);

    // Fixed priority
    req8 = 8'b0101_0010;
    #1 chk("any_req_set", 64'(any8), 64'd1);
    for (int k = 0; k < 3; k++) begin
      push(3, 6);
      step();
    end
    req8 = 8'b0000_0001;
    push(3, 0);
    step();

    // Round-robin rotation from ptr=7
    mode8 = 1'b1;
    req8  = 8'hFF;
    for (int k = 0; k < 10; k++) begin
      push(3, 7 - (k % 8));
      step();
    end
    req8 = '0;
    step();
    chk("drop_valid", 64'(v8), 64'd0);

    // Round-robin skip: ptr=5 now
    req8 = 8'b0010_0000;
    push(3, 5);
    step();
    req8 = 8'b1010_0000;
    push(3, 7);
    step();
    push(3, 5);
    step();

    // Backpressure: grant 3 (ptr=4), then stall while req changes
    req8 = 8'b0000_1000;
    push(3, 3);
    step();
    rdy8 = 1'b0;
    req8 = 8'h80;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_valid", 64'(v8), 64'd1);
      chk("hold_idx", 64'(idx8), 64'd3);
      chk("hold_onehot", 64'(oh8), 64'h08);
    end
    rdy8 = 1'b1;
    push(3, 7);
    step();
    chk("after_stall_idx", 64'(idx8), 64'd7);
    req8 = '0;
    step();
    step();

    // Parameter sweep: all requests, round-robin, ready held high
    req2 = '1; req5 = '1; req32 = '1;
    for (int k = 0; k < 40; k++) begin
      push(0, 1 - (k % 2));
      push(1, 4 - (k % 5));
      push(2, 31 - (k % 32));
      step();
    end
    req2 = '0; req5 = '0; req32 = '0;
    step();
    step();
    chk("q8_drained", 64'(q8.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    chk("q5_drained", 64'(q5.size()), 64'd0);
    chk("q32_drained", 64'(q32.size()), 64'd0);

    // Async reset in the middle of a stalled transfer
    mode8 = 1'b0;
    rdy8  = 1'b0;
    req8  = 8'h10;
    step();
    chk("pre_reset_valid", 64'(v8), 64'd1);
    chk("pre_reset_idx", 64'(idx8), 64'd4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 64'(v8), 64'd0);
    chk("async_reset_idx", 64'(idx8), 64'd0);
    chk("async_reset_onehot", 64'(oh8), 64'd0);
    req8 = '0;
    rdy8 = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("post_reset_valid", 64'(v8), 64'd0);
    chk("post_reset_any_req", 64'(any8), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
